// File: rtl/riscv_pkg.sv
// Shared types for the core pipeline control path.
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MD_WAIT  = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic en;
      logic clear;
   } stage_ctrl_t;

   localparam stage_ctrl_t STAGE_ADV   = '{en: 1'b1, clear: 1'b0};
   localparam stage_ctrl_t STAGE_HOLD  = '{en: 1'b0, clear: 1'b0};
   localparam stage_ctrl_t STAGE_FLUSH = '{en: 1'b1, clear: 1'b1};
   localparam stage_ctrl_t STAGE_RST   = '{en: 1'b0, clear: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, stall and flush controller for the 5-stage core: drives stage
// register enables/clears and the PC enable, and keeps stall/flush statistics.
module pipeline_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             md_done,
   input  logic             mem_req,
   input  logic             dmem_ready,
   input  logic             trap_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_clear,
   output logic             idex_en,
   output logic             idex_clear,
   output logic             exmem_en,
   output logic             exmem_clear,
   output logic             memwb_en,
   output logic             memwb_clear,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             md_timeout
);

   localparam int unsigned WD_W = $clog2(MD_TIMEOUT + 1);

   ctrl_state_t state_q, state_d;
   stage_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;
   logic        pc_en_c;
   logic        flush_evt_c;
   logic        mem_hold, md_hold, load_use;
   logic        wd_clr, wd_inc, wd_hit;
   logic [WD_W-1:0] wd_cnt;
   logic        md_timeout_q, md_timeout_d;

   assign mem_hold = mem_req & ~dmem_ready;
   // Once in MD_WAIT the EX op is frozen, so only md_done matters.
   assign md_hold  = (state_q == MD_WAIT) ? ~md_done : (ex_md_start & ~md_done);
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // Next state and stage controls, highest-priority hazard first.
   always_comb begin
      state_d     = RUN;
      pc_en_c     = 1'b1;
      ifid_c      = STAGE_ADV;
      idex_c      = STAGE_ADV;
      exmem_c     = STAGE_ADV;
      memwb_c     = STAGE_ADV;
      flush_evt_c = 1'b0;
      if (rst) begin
         pc_en_c = 1'b0;
         ifid_c  = STAGE_RST;
         idex_c  = STAGE_RST;
         exmem_c = STAGE_RST;
         memwb_c = STAGE_RST;
      end else if (trap_req) begin
         ifid_c      = STAGE_FLUSH;
         idex_c      = STAGE_FLUSH;
         exmem_c     = STAGE_FLUSH;
         flush_evt_c = 1'b1;
      end else if (mem_hold) begin
         pc_en_c = 1'b0;
         ifid_c  = STAGE_HOLD;
         idex_c  = STAGE_HOLD;
         exmem_c = STAGE_HOLD;
         memwb_c = STAGE_FLUSH;
         state_d = MEM_WAIT;
      end else if (md_hold) begin
         pc_en_c = 1'b0;
         ifid_c  = STAGE_HOLD;
         idex_c  = STAGE_HOLD;
         exmem_c = STAGE_FLUSH;
         state_d = MD_WAIT;
      end else if (ex_branch_taken) begin
         ifid_c      = STAGE_FLUSH;
         idex_c      = STAGE_FLUSH;
         flush_evt_c = 1'b1;
      end else if (load_use) begin
         pc_en_c = 1'b0;
         ifid_c  = STAGE_HOLD;
         idex_c  = STAGE_FLUSH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Watchdog: restarts on MD_WAIT entry, counts cycles spent in MD_WAIT.
   assign wd_clr = ~rst && (state_q != MD_WAIT) && (state_d == MD_WAIT);
   assign wd_inc = ~rst && (state_q == MD_WAIT);
   assign wd_hit = (state_q == MD_WAIT) && ~md_done &&
                   (wd_cnt == WD_W'(MD_TIMEOUT - 1));

   always_comb begin
      md_timeout_d = md_timeout_q | wd_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_timeout_q <= 1'b0;
      end else begin
         md_timeout_q <= md_timeout_d;
      end
   end

   sat_counter #(.W(WD_W)) u_wd_cnt (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .inc (wd_inc),
      .cnt (wd_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .inc (~rst & ~pc_en_c),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .inc (flush_evt_c),
      .cnt (flush_cnt)
   );

   assign pc_en       = pc_en_c;
   assign ifid_en     = ifid_c.en;
   assign ifid_clear  = ifid_c.clear;
   assign idex_en     = idex_c.en;
   assign idex_clear  = idex_c.clear;
   assign exmem_en    = exmem_c.en;
   assign exmem_clear = exmem_c.clear;
   assign memwb_en    = memwb_c.en;
   assign memwb_clear = memwb_c.clear;
   assign state       = state_q;
   assign md_timeout  = md_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; MD_TIMEOUT reduced to 4 to reach the watchdog.
module tb_pipeline_ctrl;

   localparam int unsigned CNT_W = 32;

   // {pc_en, ifid en/clr, idex en/clr, exmem en/clr, memwb en/clr}
   localparam logic [8:0] C_RST   = 9'b0_01_01_01_01;
   localparam logic [8:0] C_RUN   = 9'b1_10_10_10_10;
   localparam logic [8:0] C_LU    = 9'b0_00_11_10_10;
   localparam logic [8:0] C_BR    = 9'b1_11_11_10_10;
   localparam logic [8:0] C_MEMW  = 9'b0_00_00_00_11;
   localparam logic [8:0] C_MDW   = 9'b0_00_00_11_10;
   localparam logic [8:0] C_TRAP  = 9'b1_11_11_11_10;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
   logic ex_md_start, md_done, mem_req, dmem_ready, trap_req;
   logic pc_en, ifid_en, ifid_clear, idex_en, idex_clear;
   logic exmem_en, exmem_clear, memwb_en, memwb_clear;
   logic [1:0] state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic md_timeout;
   logic [8:0] ctl;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_en, ifid_en, ifid_clear, idex_en, idex_clear,
                 exmem_en, exmem_clear, memwb_en, memwb_clear};

   pipeline_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
      .md_done(md_done), .mem_req(mem_req), .dmem_ready(dmem_ready),
      .trap_req(trap_req), .pc_en(pc_en),
      .ifid_en(ifid_en), .ifid_clear(ifid_clear),
      .idex_en(idex_en), .idex_clear(idex_clear),
      .exmem_en(exmem_en), .exmem_clear(exmem_clear),
      .memwb_en(memwb_en), .memwb_clear(memwb_clear),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .md_timeout(md_timeout)
   );

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
      ex_md_start = 1'b0; md_done = 1'b0; mem_req = 1'b0;
      dmem_ready = 1'b0; trap_req = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl got %b exp %b", ctl, C_RST); end
      tick();
      n_chk++;
      if ({state, stall_cnt, flush_cnt, md_timeout} !== {2'd0, 32'd0, 32'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_regs got st=%0d stall=%0d flush=%0d to=%b exp 0/0/0/0",
                  state, stall_cnt, flush_cnt, md_timeout);
      end
      rst = 1'b0;
      #1;
      n_chk++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL idle_ctl got %b exp %b", ctl, C_RUN); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_stall got %b exp %b", ctl, C_LU); end
      tick();
      idle();
      #1;
      n_chk++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_release got %b exp %b", ctl, C_RUN); end
      n_chk++;
      if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
      // rs2 matches but is not read: no hazard
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
      #1;
      n_chk++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_rs2_unused got %b exp %b", ctl, C_RUN); end
      id_use_rs2 = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs2 got %b exp %b", ctl, C_LU); end
      tick();
      idle();
   endtask

   task automatic test_load_use_x0();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_x0 got %b exp %b", ctl, C_RUN); end
      tick();
      idle();
      n_chk++;
      if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL lu_x0_cnt got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_branch_over_load_use();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      ex_branch_taken = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_BR) begin n_fail++; $display("FAIL br_lu got %b exp %b", ctl, C_BR); end
      tick();
      idle();
      n_chk++;
      if ({stall_cnt, flush_cnt} !== {32'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL br_lu_cnt got stall=%0d flush=%0d exp 0/1", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++;
         if (ctl !== C_MEMW) begin n_fail++; $display("FAIL memw_ctl[%0d] got %b exp %b", i, ctl, C_MEMW); end
         tick();
         n_chk++;
         if (state !== 2'd1) begin n_fail++; $display("FAIL memw_state[%0d] got %0d exp 1", i, state); end
      end
      dmem_ready = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_BR) begin n_fail++; $display("FAIL memw_exit got %b exp %b", ctl, C_BR); end
      tick();
      idle();
      n_chk++;
      if ({state, stall_cnt, flush_cnt} !== {2'd0, 32'd3, 32'd1}) begin
         n_fail++;
         $display("FAIL memw_after got st=%0d stall=%0d flush=%0d exp 0/3/1", state, stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_md_wait();
      do_reset();
      ex_md_start = 1'b1; md_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_chk++;
         if (ctl !== C_MDW) begin n_fail++; $display("FAIL mdw_ctl[%0d] got %b exp %b", i, ctl, C_MDW); end
         tick();
         n_chk++;
         if (state !== 2'd2) begin n_fail++; $display("FAIL mdw_state[%0d] got %0d exp 2", i, state); end
      end
      md_done = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL mdw_exit got %b exp %b", ctl, C_RUN); end
      tick();
      idle();
      n_chk++;
      if ({state, stall_cnt, md_timeout} !== {2'd0, 32'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL mdw_after got st=%0d stall=%0d to=%b exp 0/4/0", state, stall_cnt, md_timeout);
      end
      // single-cycle op never stalls
      ex_md_start = 1'b1; md_done = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_RUN) begin n_fail++; $display("FAIL md_single got %b exp %b", ctl, C_RUN); end
      tick();
      idle();
      n_chk++;
      if ({state, stall_cnt} !== {2'd0, 32'd4}) begin
         n_fail++;
         $display("FAIL md_single_after got st=%0d stall=%0d exp 0/4", state, stall_cnt);
      end
   endtask

   task automatic test_md_timeout();
      do_reset();
      ex_md_start = 1'b1; md_done = 1'b0;
      tick();
      for (int i = 1; i <= 3; i++) tick();
      n_chk++;
      if (md_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early got %b exp 0", md_timeout); end
      tick();
      n_chk++;
      if ({md_timeout, state} !== {1'b1, 2'd2}) begin
         n_fail++;
         $display("FAIL wd_fire got to=%b st=%0d exp 1/2", md_timeout, state);
      end
      trap_req = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_TRAP) begin n_fail++; $display("FAIL wd_trap got %b exp %b", ctl, C_TRAP); end
      tick();
      idle();
      tick();
      n_chk++;
      if ({state, md_timeout, flush_cnt} !== {2'd0, 1'b1, 32'd1}) begin
         n_fail++;
         $display("FAIL wd_sticky got st=%0d to=%b flush=%0d exp 0/1/1", state, md_timeout, flush_cnt);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (md_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_rst got %b exp 0", md_timeout); end
   endtask

   task automatic test_trap_mem_wait();
      do_reset();
      mem_req = 1'b1; dmem_ready = 1'b0;
      tick();
      n_chk++;
      if (state !== 2'd1) begin n_fail++; $display("FAIL trap_pre got %0d exp 1", state); end
      trap_req = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_TRAP) begin n_fail++; $display("FAIL trap_ctl got %b exp %b", ctl, C_TRAP); end
      tick();
      trap_req = 1'b0;
      n_chk++;
      if ({state, stall_cnt, flush_cnt} !== {2'd0, 32'd1, 32'd1}) begin
         n_fail++;
         $display("FAIL trap_after got st=%0d stall=%0d flush=%0d exp 0/1/1", state, stall_cnt, flush_cnt);
      end
      tick();
      n_chk++;
      if ({state, stall_cnt} !== {2'd1, 32'd2}) begin
         n_fail++;
         $display("FAIL trap_rewait got st=%0d stall=%0d exp 1/2", state, stall_cnt);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (ctl !== C_RST) begin n_fail++; $display("FAIL mid_rst_ctl got %b exp %b", ctl, C_RST); end
      tick();
      n_chk++;
      if ({state, stall_cnt, flush_cnt} !== {2'd0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL mid_rst got st=%0d stall=%0d flush=%0d exp 0/0/0", state, stall_cnt, flush_cnt);
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_load_use_x0();
      test_branch_over_load_use();
      test_mem_wait();
      test_md_wait();
      test_md_timeout();
      test_trap_mem_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
